// File: rtl/pe_dbuf_if.sv
// Systolic PE neighbour bus: activation, shadow-weight chain, partial sum and status.
// slave is the PE side; master is the array/feeder side.
interface pe_dbuf_if #(
    parameter int unsigned CDW = 4,
    parameter int unsigned ACC = 16
);
    logic signed [CDW-1:0] data_in;
    logic                  data_valid_in;
    logic signed [CDW-1:0] data_out;
    logic                  data_valid_out;
    logic signed [CDW-1:0] weight_in;
    logic                  weight_shift;
    logic signed [CDW-1:0] weight_out;
    logic                  weight_swap;
    logic signed [ACC-1:0] psum_in;
    logic signed [ACC-1:0] psum_out;
    logic                  psum_valid_out;
    logic                  active_loaded;
    logic                  ovf;
    logic                  ovf_clr;

    modport slave (
        input  data_in, data_valid_in, weight_in, weight_shift, weight_swap, psum_in, ovf_clr,
        output data_out, data_valid_out, weight_out, psum_out, psum_valid_out, active_loaded, ovf
    );

    modport master (
        output data_in, data_valid_in, weight_in, weight_shift, weight_swap, psum_in, ovf_clr,
        input  data_out, data_valid_out, weight_out, psum_out, psum_valid_out, active_loaded, ovf
    );
endinterface

// File: rtl/pe_dbuf.sv
// Signed MAC processing element with shadow/active double-buffered weight and sticky overflow.
// Optional PE_SATURATE_EN: clamp psum_out on overflow instead of two's-complement wrap.
module pe_dbuf #(
    parameter int unsigned COMPUTE_DATA_WIDTH     = 4,
    parameter int unsigned ACCUMULATOR_DATA_WIDTH = 16
) (
    input logic     clk,
    input logic     rst_n,
    pe_dbuf_if.slave bus
);
    localparam int unsigned CDW = COMPUTE_DATA_WIDTH;
    localparam int unsigned ACC = ACCUMULATOR_DATA_WIDTH;
    localparam int unsigned PW  = 2 * CDW;

    if (ACC < PW) begin : g_width_check
        $error("pe_dbuf: ACCUMULATOR_DATA_WIDTH must be >= 2*COMPUTE_DATA_WIDTH");
    end

    logic signed [CDW-1:0] shadow_q, shadow_d;
    logic signed [CDW-1:0] active_q, active_d;
    logic                  shadow_loaded_q, shadow_loaded_d;
    logic                  active_loaded_q, active_loaded_d;
    logic signed [CDW-1:0] data_q, data_d;
    logic                  data_valid_q, data_valid_d;
    logic signed [ACC-1:0] psum_q, psum_d;
    logic                  psum_valid_q, psum_valid_d;
    logic                  ovf_q, ovf_d;

    logic signed [PW-1:0]  prod_c;
    logic signed [ACC-1:0] addend_c;
    logic signed [ACC-1:0] sum_c;
    logic                  ovf_now_c;

    // Next-state: the MAC reads active_q, so a same-edge swap only affects the following cycle.
    always_comb begin
        shadow_d        = shadow_q;
        active_d        = active_q;
        shadow_loaded_d = shadow_loaded_q;
        active_loaded_d = active_loaded_q;
        data_d          = bus.data_in;
        data_valid_d    = bus.data_valid_in;
        psum_d          = bus.psum_in;
        psum_valid_d    = 1'b0;
        ovf_d           = ovf_q;

        prod_c    = PW'(bus.data_in) * PW'(active_q);
        addend_c  = ACC'(prod_c);
        sum_c     = bus.psum_in + addend_c;
        ovf_now_c = bus.data_valid_in
                    && (bus.psum_in[ACC-1] == addend_c[ACC-1])
                    && (sum_c[ACC-1] != bus.psum_in[ACC-1]);

        if (bus.weight_swap) begin
            active_d        = shadow_q;
            active_loaded_d = shadow_loaded_q;
            shadow_loaded_d = 1'b0;
        end
        if (bus.weight_shift) begin
            shadow_d        = bus.weight_in;
            shadow_loaded_d = 1'b1;
        end

        if (bus.data_valid_in) begin
            psum_d       = sum_c;
            psum_valid_d = 1'b1;
`ifdef PE_SATURATE_EN
            if (ovf_now_c) begin
                psum_d = bus.psum_in[ACC-1] ? {1'b1, {(ACC-1){1'b0}}}
                                            : {1'b0, {(ACC-1){1'b1}}};
            end
`endif
        end

        // A new overflow takes priority over a clear on the same cycle.
        if (ovf_now_c) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q        <= '0;
            active_q        <= '0;
            shadow_loaded_q <= 1'b0;
            active_loaded_q <= 1'b0;
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            psum_q          <= '0;
            psum_valid_q    <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            shadow_q        <= shadow_d;
            active_q        <= active_d;
            shadow_loaded_q <= shadow_loaded_d;
            active_loaded_q <= active_loaded_d;
            data_q          <= data_d;
            data_valid_q    <= data_valid_d;
            psum_q          <= psum_d;
            psum_valid_q    <= psum_valid_d;
            ovf_q           <= ovf_d;
        end
    end

    assign bus.data_out       = data_q;
    assign bus.data_valid_out = data_valid_q;
    assign bus.weight_out     = shadow_q;
    assign bus.psum_out       = psum_q;
    assign bus.psum_valid_out = psum_valid_q;
    assign bus.active_loaded  = active_loaded_q;
    assign bus.ovf            = ovf_q;
endmodule

// File: tb/tb_pe_dbuf.sv
// Scoreboard bench for pe_dbuf: each driven cycle queues its expected outputs, a monitor checks them.
module tb_pe_dbuf;
    localparam int unsigned CDW = 4;
    localparam int unsigned ACC = 16;

    localparam int M_PSUM = 1;
    localparam int M_PV   = 2;
    localparam int M_DOUT = 4;
    localparam int M_DV   = 8;
    localparam int M_WOUT = 16;
    localparam int M_AL   = 32;
    localparam int M_OVF  = 64;

    typedef struct {
        string name;
        int    mask;
        int    psum;
        int    pv;
        int    dout;
        int    dv;
        int    wout;
        int    al;
        int    ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    pe_dbuf_if #(.CDW(CDW), .ACC(ACC)) bus ();

    pe_dbuf #(
        .COMPUTE_DATA_WIDTH    (CDW),
        .ACCUMULATOR_DATA_WIDTH(ACC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one queued expectation per driven cycle, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            if ((e.mask & M_PSUM) != 0) chk({e.name, ".psum_out"},       int'(bus.psum_out),      e.psum);
            if ((e.mask & M_PV)   != 0) chk({e.name, ".psum_valid_out"}, int'(bus.psum_valid_out), e.pv);
            if ((e.mask & M_DOUT) != 0) chk({e.name, ".data_out"},       int'(bus.data_out),      e.dout);
            if ((e.mask & M_DV)   != 0) chk({e.name, ".data_valid_out"}, int'(bus.data_valid_out), e.dv);
            if ((e.mask & M_WOUT) != 0) chk({e.name, ".weight_out"},     int'(bus.weight_out),    e.wout);
            if ((e.mask & M_AL)   != 0) chk({e.name, ".active_loaded"},  int'(bus.active_loaded), e.al);
            if ((e.mask & M_OVF)  != 0) chk({e.name, ".ovf"},            int'(bus.ovf),           e.ovf);
        end
    end

    function automatic exp_t mk(input string name, input int mask, input int psum, input int pv,
                                input int dout, input int dv, input int wout, input int al,
                                input int ovf);
        exp_t e;
        e.name = name; e.mask = mask; e.psum = psum; e.pv = pv; e.dout = dout;
        e.dv = dv; e.wout = wout; e.al = al; e.ovf = ovf;
        return e;
    endfunction

    task automatic step(input int din, input bit dv, input int win, input bit shift,
                        input bit swap, input int psin, input bit clr, input exp_t e);
        @(negedge clk);
        bus.data_in       = CDW'(din);
        bus.data_valid_in = dv;
        bus.weight_in     = CDW'(win);
        bus.weight_shift  = shift;
        bus.weight_swap   = swap;
        bus.psum_in       = ACC'(psin);
        bus.ovf_clr       = clr;
        sb.push_back(e);
    endtask

    localparam int MW = M_WOUT | M_AL;
    localparam int MP = M_PSUM | M_PV;

`ifdef PE_SATURATE_EN
    localparam int POS_OVF = 32767;
    localparam int NEG_OVF = -32768;
`else
    localparam int POS_OVF = -32727;
    localparam int NEG_OVF = 32712;
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.data_in = '0; bus.data_valid_in = 1'b0; bus.weight_in = '0;
        bus.weight_shift = 1'b0; bus.weight_swap = 1'b0; bus.psum_in = '0; bus.ovf_clr = 1'b0;

        #12;
        chk("reset.psum_out",       int'(bus.psum_out),       0);
        chk("reset.psum_valid_out", int'(bus.psum_valid_out), 0);
        chk("reset.data_valid_out", int'(bus.data_valid_out), 0);
        chk("reset.weight_out",     int'(bus.weight_out),     0);
        chk("reset.active_loaded",  int'(bus.active_loaded),  0);
        chk("reset.ovf",            int'(bus.ovf),            0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load -3, commit, then MAC
        step(0, 0, -3, 1, 0, 0, 0, mk("shift1", MW | MP, 0, 0, 0, 0, -3, 0, 0));
        step(0, 0,  0, 0, 1, 0, 0, mk("swap1",  MW, 0, 0, 0, 0, -3, 1, 0));
        step(7, 1,  0, 0, 0, 10, 0, mk("mac1", 127, -11, 1, 7, 1, -3, 1, 0));

        // Same-cycle swap uses the old active weight
        step(0, 0, 2, 1, 0, 0, 0, mk("shift2", M_WOUT, 0, 0, 0, 0, 2, 0, 0));
        step(0, 0, 0, 0, 1, 0, 0, mk("swap2",  M_AL, 0, 0, 0, 0, 0, 1, 0));
        step(0, 0, 5, 1, 0, 0, 0, mk("shift5", M_WOUT, 0, 0, 0, 0, 5, 0, 0));
        step(3, 1, 0, 0, 1, 0, 0, mk("macswap", MP, 6, 1, 0, 0, 0, 0, 0));
        step(3, 1, 0, 0, 0, 0, 0, mk("macnew",  MP, 15, 1, 0, 0, 0, 0, 0));

        // Shift and swap together
        step(0, 0,  4, 1, 0, 0, 0, mk("shift4",  M_WOUT, 0, 0, 0, 0, 4, 0, 0));
        step(0, 0, -8, 1, 1, 0, 0, mk("collide", MW, 0, 0, 0, 0, -8, 1, 0));
        step(1, 1,  0, 0, 0, 0, 0, mk("macact4", MP, 4, 1, 0, 0, 0, 0, 0));

        // Bubble passes psum through
        step(5, 0, 0, 0, 0, 1234, 0, mk("bubble", MP | M_DOUT | M_DV | M_OVF, 1234, 0, 5, 0, 0, 0, 0));

        // Positive overflow, sticky, clear
        step(0, 0, 7, 1, 0, 0, 0, mk("shift7", M_WOUT, 0, 0, 0, 0, 7, 0, 0));
        step(0, 0, 0, 0, 1, 0, 0, mk("swap7",  M_AL, 0, 0, 0, 0, 0, 1, 0));
        step(7, 1, 0, 0, 0, 32760, 0, mk("ovfpos", MP | M_OVF, POS_OVF, 1, 0, 0, 0, 0, 1));
        step(0, 0, 0, 0, 0, -5, 0, mk("ovfsticky", MP | M_OVF, -5, 0, 0, 0, 0, 0, 1));
        step(0, 0, 0, 0, 0, 0, 1, mk("ovfclr", M_OVF, 0, 0, 0, 0, 0, 0, 0));

        // Negative overflow with clear on the same cycle: set wins
        step(-8, 1, 0, 0, 0, -32768, 1, mk("ovfneg", MP | M_OVF, NEG_OVF, 1, 0, 0, 0, 0, 1));
        step(0, 0, 0, 0, 0, 0, 1, mk("ovfclr2", M_OVF, 0, 0, 0, 0, 0, 0, 0));

        // Swap without a fresh shift copies the stale shadow, active_loaded drops
        step(0, 0, 0, 0, 1, 0, 0, mk("staleswap", MW, 0, 0, 0, 0, 7, 0, 0));
        step(1, 1, 0, 0, 0, 0, 0, mk("stalemac", MP | M_OVF, 7, 1, 0, 0, 0, 0, 0));

        // Valid traffic, then async reset between edges
        step(3, 1, 0, 0, 0, 100, 0, mk("premst", MP | M_DOUT, 121, 1, 3, 0, 0, 0, 0));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.psum_out",       int'(bus.psum_out),       0);
        chk("areset.psum_valid_out", int'(bus.psum_valid_out), 0);
        chk("areset.data_out",       int'(bus.data_out),       0);
        chk("areset.data_valid_out", int'(bus.data_valid_out), 0);
        chk("areset.weight_out",     int'(bus.weight_out),     0);
        chk("areset.active_loaded",  int'(bus.active_loaded),  0);
        chk("areset.ovf",            int'(bus.ovf),            0);
        @(negedge clk);
        rst_n = 1'b1;

        // Active was cleared by reset: MAC passes psum through
        step(7, 1, 0, 0, 0, 55, 0, mk("postrst", MP | M_AL, 55, 1, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        chk("scoreboard.drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, total=%0d", total);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pe_dbuf.md
Name: pe_dbuf

Overview:
- Next-generation systolic-array processing element: signed MAC cell with a double-buffered (shadow/active) weight register.
- Weights are daisy-chained down the column through a shift path. The next tile's weights can be preloaded while the current tile computes, then committed with a single swap pulse.
- Data and partial sums carry valid tags, so bubbles propagate cleanly through the array.
- Sticky overflow detection on the accumulate path.
- Instantiated NxN by the array wrapper, replacing the single-buffered PE.

Parameters:
- COMPUTE_DATA_WIDTH, 4, signed width of data and weight operands.
- ACCUMULATOR_DATA_WIDTH, 16, signed width of partial sums; must be >= 2*COMPUTE_DATA_WIDTH (elaboration-time assertion).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  CDW  signed activation from the left neighbour.
- data_valid_in  in  1  data_in is valid; enables MAC this cycle.
- data_out  out  CDW  registered data_in to the right neighbour.
- data_valid_out  out  1  registered data_valid_in.
- weight_in  in  CDW  shadow-weight input from the PE above (or the weight feeder).
- weight_shift  in  1  load weight_in into the shadow register.
- weight_out  out  CDW  shadow register value, to the PE below.
- weight_swap  in  1  commit shadow to active.
- psum_in  in  ACC  signed partial sum from above.
- psum_out  out  ACC  registered partial sum downward.
- psum_valid_out  out  1  psum_out carries a MAC result.
- active_loaded  out  1  active weight has been committed since reset.
- ovf  out  1  sticky accumulate overflow flag.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (async, rst_n=0): shadow, active, data_out, psum_out, weight_out = 0; data_valid_out, psum_valid_out, active_loaded, ovf, shadow_loaded (internal) = 0. Reset mid-operation discards all state immediately; there is no partial commit.
- All outputs are registered. Latency is 1 cycle for data, valid and psum.
- Data path: data_out <= data_in and data_valid_out <= data_valid_in, every cycle, unconditionally.
- Weight shift:
  - If weight_shift: shadow <= weight_in and shadow_loaded <= 1.
  - weight_out is the shadow register, so a column of N PEs loads in N shift cycles, bottom PE's weight first.
- Weight swap:
  - If weight_swap: active <= shadow, active_loaded <= shadow_loaded, shadow_loaded <= 0.
  - Swap with shadow_loaded=0 still copies shadow (stale value).
- Simultaneous shift and swap: active takes the OLD shadow; shadow takes weight_in; shadow_loaded ends at 1.
- MAC, when data_valid_in=1:
  - prod = data_in * active, a full 2*CDW signed product, sign-extended to ACC.
  - psum_out <= psum_in + prod; psum_valid_out <= 1.
  - The MAC always uses the active value from BEFORE the edge, including a swap on the same cycle.
- Bubble, when data_valid_in=0: psum_out <= psum_in (pass-through, keeps the column chain intact); psum_valid_out <= 0; no overflow check.
- Overflow:
  - Detected when both addends have the same sign and the sum's sign differs.
  - Sets ovf (sticky).
  - If ovf_clr and a new overflow occur on the same cycle, set wins (ovf=1).
- active_loaded=0 with valid data is legal: active=0, so psum_out = psum_in.

Optional Feature:
- Macro PE_SATURATE_EN.
- Defined: on overflow, psum_out clamps to +2^(ACC-1)-1 (positive overflow) or -2^(ACC-1) (negative overflow); ovf is still set.
- Undefined: two's-complement wrap; ovf is still set.
- Bubble pass-through is unaffected in both builds.

Test Plan (CDW=4, ACC=16):
- Reset/shift/swap/MAC:
  - Reset, then weight_in=-3 with weight_shift for 1 cycle, then weight_swap.
  - Then data_in=7, valid=1, psum_in=10 -> next cycle psum_out=-11, psum_valid_out=1, data_out=7, active_loaded=1.
- Same-cycle swap:
  - Active=2, shadow=5.
  - Drive weight_swap together with data_in=3, psum_in=0 -> psum_out=6.
  - Next valid data_in=3, psum_in=0 -> psum_out=15.
- Shift+swap collision:
  - shadow=4, weight_in=-8, both weight_shift and weight_swap -> active=4, shadow=weight_out=-8.
- Bubble: data_valid_in=0, psum_in=1234 -> psum_out=1234, psum_valid_out=0, ovf unchanged.
- Overflow:
  - active=7, data_in=7, psum_in=32760 -> ovf=1.
  - psum_out=-32727 without PE_SATURATE_EN; psum_out=32767 with it.
  - Then pulse ovf_clr -> ovf=0.
- Async reset mid-stream: assert rst_n=0 between edges during valid traffic -> all outputs 0 immediately, before the next clk edge.
